// File: rtl/buff_uart_pkg.sv
// rtl/buff_uart_pkg.sv - shared word width, FIFO depth and count-width helper for buff_uart
package buff_uart_pkg;

  localparam int UART_WORD_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Occupancy needs one bit more than a pointer so that 0..DEPTH all fit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x WIDTH register array, one write port, asynchronous read
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit word buffer feeding the UART transmitter
module uart_tx_fifo
  import buff_uart_pkg::*;
#(
  parameter int WIDTH             = UART_WORD_WIDTH,
  parameter int DEPTH             = UART_FIFO_DEPTH,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             overflow_q;
  logic             tx_ready_q;
  logic             tx_send_q;
  logic             wr_en;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign wr_ready    = !full;
  assign count       = count_q;
  assign overflow    = overflow_q;

  assign tx_send = !empty;
  assign tx_data = empty ? '0 : head;

  // The transmitter drops ready on the edge it latches; a ready level alone
  // (which rises during the stop bit) must never pop.
  assign accept = tx_ready_q && !tx_ready && tx_send_q;
  assign wr_en  = wr_valid && wr_ready && !flush;
  assign pop    = accept && !empty && !flush;

  assign count_next = count_q + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_send_q  <= 1'b0;
    end else begin
      tx_ready_q <= tx_ready;
      tx_send_q  <= tx_send;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_valid && full) begin
          overflow_q <= 1'b1;
        end
        count_q <= count_next;
      end
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;
  logic       wr_ready, tx_send, empty, full, almost_full, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  // Transmitter model: latches when idle and offered, busy for a 10-bit
  // frame at 4 clocks per bit, raising ready during the stop bit.
  bit         model_en = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] latched[$];

  typedef struct {
    logic [7:0] data;
    int         cnt;
    bit         f;
    bit         af;
    bit         wr;
    bit         ov;
  } vec_t;
  vec_t vec[17];

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .ALMOST_FULL_LEVEL(12)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .flush       (flush),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_ready    (tx_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic       s;
    logic [7:0] d;
    s = tx_send;
    d = tx_data;
    @(posedge clock);
    #1;
    if (model_en) begin
      if (tx_cnt == 0 && tx_ready && s) begin
        latched.push_back(d);
        tx_cnt   = 40;
        tx_ready = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt <= 3) tx_ready = 1'b1;
      end
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic reset_state_checks(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
    chk({tag, "_tx_send"}, 32'(tx_send), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    logic [7:0] exp_words[3];
    exp_words[0] = 8'h55;
    exp_words[1] = 8'hA3;
    exp_words[2] = 8'h0F;
    for (int i = 0; i < 17; i++) begin
      vec[i].data = (i < 16) ? 8'(i) : 8'hFF;
      vec[i].cnt  = (i < 16) ? i + 1 : 16;
      vec[i].f    = (i >= 15);
      vec[i].af   = (i >= 11);
      vec[i].wr   = (i < 15);
      vec[i].ov   = (i == 16);
    end

    #12;
    reset_state_checks("reset");
    step();
    resetn = 1'b1;
    step();

    // Three words through the transmitter model.
    model_en = 1'b1;
    wr(8'h55);
    wr(8'hA3);
    wr(8'h0F);
    chk("t1_count3", 32'(count), 3);
    tx_ready = 1'b1;
    for (int i = 0; i < 600 && !(latched.size() == 3 && empty); i++) step();
    chk("t1_latched_n", 32'(latched.size()), 3);
    for (int i = 0; i < 3 && i < latched.size(); i++)
      chk($sformatf("t1_word%0d", i), 32'(latched[i]), 32'(exp_words[i]));
    chk("t1_count0", 32'(count), 0);
    chk("t1_tx_send", 32'(tx_send), 0);
    chk("t1_overflow", 32'(overflow), 0);
    for (int i = 0; i < 100 && tx_cnt != 0; i++) step();
    chk("t1_model_idle", 32'(tx_cnt), 0);
    model_en = 1'b0;
    tx_ready = 1'b0;
    step();
    step();

    // Fill to full and one beyond, ready held low.
    for (int i = 0; i < 17; i++) begin
      wr(vec[i].data);
      chk($sformatf("t2_count_%0d", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("t2_full_%0d", i), 32'(full), 32'(vec[i].f));
      chk($sformatf("t2_afull_%0d", i), 32'(almost_full), 32'(vec[i].af));
      chk($sformatf("t2_wr_ready_%0d", i), 32'(wr_ready), 32'(vec[i].wr));
      chk($sformatf("t2_overflow_%0d", i), 32'(overflow), 32'(vec[i].ov));
      chk($sformatf("t2_head_%0d", i), 32'(tx_data), 0);
    end

    // Acceptance and write in the same cycle on a full FIFO.
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    wr(8'hEE);
    chk("t3_count15", 32'(count), 15);
    chk("t3_head", 32'(tx_data), 32'h01);
    wr(8'h77);
    chk("t3_count16", 32'(count), 16);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("t3_drain_%0d", j), 32'(tx_data), (j < 15) ? 32'(j + 1) : 32'h77);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      step();
    end
    chk("t3_empty", 32'(empty), 1);
    chk("t3_tx_send", 32'(tx_send), 0);
    chk("t3_overflow_sticky", 32'(overflow), 1);

    // Ready level never pops; a single falling edge pops exactly once.
    wr(8'hA1);
    wr(8'hB2);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t4_level_count", 32'(count), 2);
    chk("t4_level_head", 32'(tx_data), 32'hA1);
    tx_ready = 1'b0;
    chk("t4_prepop_head", 32'(tx_data), 32'hA1);
    step();
    chk("t4_pop_count", 32'(count), 1);
    chk("t4_pop_head", 32'(tx_data), 32'hB2);
    for (int i = 0; i < 5; i++) step();
    chk("t4_single_pop", 32'(count), 1);

    // Flush concurrent with an acceptance.
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
    chk("t5_count5", 32'(count), 5);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_overflow", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_underflow", 32'(count), 0);
    latched.delete();
    tx_cnt   = 0;
    model_en = 1'b1;
    tx_ready = 1'b1;
    wr(8'h3C);
    for (int i = 0; i < 20 && latched.size() == 0; i++) step();
    chk("t5_latched_n", 32'(latched.size()), 1);
    if (latched.size() > 0) chk("t5_next_word", 32'(latched[0]), 32'h3C);
    step();
    chk("t5_popped", 32'(count), 0);

    // Asynchronous reset mid-frame with four words stored.
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_count", 32'(count), 4);
    #1;
    resetn = 1'b0;
    #2;
    reset_state_checks("t6_async");
    #3;
    resetn = 1'b1;
    for (int i = 0; i < 80; i++) step();
    chk("t6_post_count", 32'(count), 0);
    chk("t6_post_empty", 32'(empty), 1);
    chk("t6_post_tx_send", 32'(tx_send), 0);
    chk("t6_no_spurious", 32'(latched.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side word buffer that sits directly upstream of the UART transmitter in buff_uart.
- Accepts words from a producer through a valid/ready write port.
- Stores up to DEPTH words.
- Presents the head word to the transmitter through its data / can_send_next_word / ready interface.
- Pops a word only once the transmitter has provably latched it, so the producer never has to wait on UART bit timing.

Parameters:
- WIDTH, 8: word width in bits; must equal the transmitter's data width.
- DEPTH, 16: number of entries; a power of two, at least 2.
- ALMOST_FULL_LEVEL, 12: occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clock, in, 1: single clock for the block; everything is sampled on the rising edge.
- resetn, in, 1: asynchronous active-low reset.
- wr_valid, in, 1: producer offers wr_data.
- wr_data, in, WIDTH: word to enqueue.
- wr_ready, out, 1: FIFO can take a word this cycle.
- flush, in, 1: synchronous discard of all stored words.
- tx_data, out, WIDTH: head word, drives the transmitter's data input.
- tx_send, out, 1: drives the transmitter's can_send_next_word.
- tx_ready, in, 1: the transmitter's ready output.
- count, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- empty, out, 1: count == 0.
- full, out, 1: count == DEPTH.
- almost_full, out, 1: count >= ALMOST_FULL_LEVEL.
- overflow, out, 1: sticky; a write was attempted while full.

Behaviour:
- Reset (resetn low, asynchronous):
  - Read/write pointers = 0, count = 0, overflow = 0, tx_ready_q = 0, tx_send_q = 0.
  - Outputs: empty = 1, full = 0, almost_full = 0, wr_ready = 1, tx_send = 0, tx_data = 0.
  - Storage contents are don't-care but must not reach tx_data while empty; tx_data is forced to 0 when empty.
  - Reset is permitted mid-transfer. The transmitter keeps whatever word it already holds; the FIFO simply restarts empty.
- Flags:
  - wr_ready = !full. It is combinational from registered count only, with no dependency on wr_valid.
  - empty, full and almost_full are decoded from registered count.
- Write: when wr_valid && wr_ready, mem[wr_ptr] <= wr_data and wr_ptr wraps modulo DEPTH.
- Write while full: the word is dropped, overflow <= 1, and no pointer or count changes. overflow clears only on reset or flush.
- Transmit side:
  - tx_send = !empty and tx_data = mem[rd_ptr], both combinational from registered state.
  - The transmitter latches data on the edge where it samples can_send_next_word while idle, and drops ready on that same edge.
  - Acceptance: tx_ready_q registers tx_ready and tx_send_q registers tx_send. Acceptance = tx_ready_q && !tx_ready && tx_send_q, i.e. a falling edge of ready while we were offering.
  - On acceptance, pop: rd_ptr advances (wraps) and count decrements.
  - Pop latency: 1 cycle after the transmitter latches. tx_data must stay stable until the pop, which this guarantees.
  - A ready high level alone never pops. Ready rises during the stop bit, before the transmitter can actually accept.
  - tx_send stays high for the pop cycle; the transmitter ignores it because it is busy.
- Simultaneous write and pop: both take effect and count is unchanged. Pop from a full FIFO plus a write in the same cycle is legal, because wr_ready is evaluated from the pre-pop count (write is refused when full, even with a concurrent pop).
- Pop qualified by empty: if acceptance is detected while count == 0 (possible after a flush), the pop is suppressed and no pointer moves.
- Flush:
  - rd_ptr = wr_ptr = 0, count = 0, overflow = 0 on the next edge.
  - A concurrent write in the same cycle is discarded.
  - A pending acceptance in the same cycle is ignored.
- Width rules:
  - Pointers are $clog2(DEPTH) bits with natural wrap.
  - count is one bit wider and never exceeds DEPTH or goes below 0.
  - Acceptance and write update count with a single combined ±1/0 expression.

Decomposition:
- Shared package buff_uart_pkg holds:
  - UART_WORD_WIDTH = 8.
  - Default FIFO depth constant.
  - Count width helper function (clog2 + 1).
- Both this block and the transmitter interface take their width from the package.
- One natural sub-module: uart_fifo_mem, a DEPTH x WIDTH register array with one write port and an asynchronous read.
- Pointers, count and handshake edge detection stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0x55, 0xA3, 0x0F with the real transmitter at clock_freq/baud_rate = 4 → serial line carries exactly those three frames in order; count goes 3→0; tx_send drops after the third pop; overflow stays 0.
- Write 16 words 0x00..0x0F with tx_ready held 0 → full = 1 and wr_ready = 0 after the 16th; a 17th write of 0xFF leaves count = 16 and sets overflow = 1; almost_full has been 1 since count = 12.
- Hold tx_ready constantly 1 with 2 words stored → no pop occurs and count stays 2. Then drive tx_ready 1→0 once → exactly one pop, and tx_data changes to the second word one cycle later.
- Full FIFO, acceptance and wr_valid in the same cycle → write refused, pop performed, count = 15. Next cycle write 0x77 → count = 16, 0x77 exits last after wrap.
- 5 words stored, flush asserted on the same cycle as a ready falling edge → count = 0, empty = 1, no pointer underflow, overflow = 0, and the next written word 0x3C is the next word transmitted.
- Assert resetn low asynchronously mid-frame with 4 words stored → all outputs at reset values immediately without waiting for a clock edge; after release the FIFO is empty and no spurious pop occurs.
